// File: rtl/serial_odd_parity_checker.sv
// Serial odd-parity frame checker: N data bits LSB first, then one parity bit.
// Optional saturating error counter is enabled with `define PARITY_ERR_COUNT_EN.
module serial_odd_parity_checker #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] data_out,
  output logic         parity_err,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   err_count
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    RECV,
    HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           xor_q, xor_d;
  logic [N-1:0]   data_q, data_d;
  logic           perr_q, perr_d;
  logic           frame_done;

  assign frame_done = (state_q == RECV) && in_valid && (cnt_q == CW'(N));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    data_d  = data_q;
    perr_d  = perr_q;
    case (state_q)
      RECV: begin
        if (in_valid) begin
          if (cnt_q == CW'(N)) begin
            perr_d  = ~(xor_q ^ in_bit);
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            for (int unsigned i = 0; i < N; i++) begin
              if (cnt_q == CW'(i)) data_d[i] = in_bit;
            end
            xor_d = xor_q ^ in_bit;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = RECV;
          xor_d   = 1'b0;
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RECV;
      cnt_q   <= '0;
      xor_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
    end
  end

`ifdef PARITY_ERR_COUNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (frame_done && perr_d && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_count = err_q;
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
  assign err_count         = '0;
`endif

  assign in_ready   = (state_q == RECV);
  assign out_valid  = (state_q == HOLD);
  assign data_out   = data_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_serial_odd_parity_checker.sv
// Scoreboard bench for serial_odd_parity_checker (N=4): directed and random frames.
module tb_serial_odd_parity_checker;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_bit = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] data_out;
  logic         parity_err;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   err_count;

  serial_odd_parity_checker #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .parity_err(parity_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] d;
    logic         e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   ready_mode = 2;  // 0 random, 1 stall, 2 always ready

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_err_count(input int c);
`ifdef PARITY_ERR_COUNT_EN
    return 32'(c);
`else
    return (c > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Consumer side: out_ready policy
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops expected frame on each output handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        chk("in_ready_in_hold", 32'(in_ready), 32'd0);
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("spurious_frame", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("data_out", 32'(data_out), 32'(e.d));
            chk("parity_err", 32'(parity_err), 32'(e.e));
            if (e.e && exp_cnt < 255) exp_cnt++;
            chk("err_count", 32'(err_count), exp_err_count(exp_cnt));
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b, input int gap);
    int k = 0;
    in_valid = 1'b1;
    in_bit   = b;
    @(negedge clk);
    while (!in_ready && k < 500) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'($urandom_range(0, 1));
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      in_bit = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic p, input int gap);
    exp_t e;
    e.d = d;
    e.e = (($countones({p, d}) % 2) == 0);
    q.push_back(e);
    for (int i = 0; i < N; i++) send_bit(d[i], gap);
    send_bit(p, 0);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data_out"}, 32'(data_out), 32'd0);
    chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    logic [N-1:0] dv;
    logic         pv;
    logic [N-1:0] rd;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Good frame, then bad frame with same data
    send_frame(4'b1011, 1'b0, 0);
    send_frame(4'b1011, 1'b1, 0);
    // Zeros with idle gaps between bits
    send_frame(4'b0000, 1'b1, 3);
    wait_drain();

    // Stall consumer; inputs must be ignored while holding
    ready_mode = 1;
    @(posedge clk);
    #1;
    send_frame(4'b1100, 1'b1, 0);
    dv = data_out;
    pv = parity_err;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_bit   = 1'(k);
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(data_out), 32'(dv));
      chk("stall_perr", 32'(parity_err), 32'(pv));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ready_mode = 2;
    send_frame(4'b0101, 1'b0, 0);
    wait_drain();

    // Reset in the middle of a frame
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(4'b0110, 1'b1, 0);
    wait_drain();

    // Reset while holding a frame
    ready_mode = 1;
    @(posedge clk);
    #1;
    send_frame(4'b1111, 1'b1, 0);
    void'(q.pop_front());
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("holdrst");
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 2;
    send_frame(4'b1001, 1'b0, 0);
    wait_drain();

    // Random frames with random gaps and random consumer stalls
    ready_mode = 0;
    for (int f = 0; f < 40; f++) begin
      rd = N'($urandom);
      send_frame(rd, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    wait_drain();

    // Error counter saturation
    ready_mode = 2;
    for (int f = 0; f < 260; f++) begin
      rd = N'($urandom);
      send_frame(rd, ^rd, 0);
    end
    wait_drain();
    chk("err_count_sat", 32'(err_count), exp_err_count(255));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    chk("global_timeout", 32'd1, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_odd_parity_checker.md
SERIAL_ODD_PARITY_CHECKER -- requirements
Module: serial_odd_parity_checker

Interface
REQ-001 SHALL have parameter N, default 4, number of data bits per frame (N >= 1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port in_bit  input  1  serial frame bit: N data bits LSB first, then 1 parity bit.
REQ-005 SHALL have port in_valid  input  1  in_bit valid this cycle.
REQ-006 SHALL have port in_ready  output  1  checker can accept a bit; a bit transfers when in_valid & in_ready.
REQ-007 SHALL have port data_out  output  N  received data word, data_out[i] = i-th data bit received.
REQ-008 SHALL have port parity_err  output  1  high when received frame fails odd parity; qualified by out_valid.
REQ-009 SHALL have port out_valid  output  1  data_out/parity_err hold a completed frame.
REQ-010 SHALL have port out_ready  input  1  consumer accepts frame; transfer when out_valid & out_ready.
REQ-011 SHALL have port err_count  output  8  count of frames with parity_err (see Configuration).

Function
REQ-012 SHALL implement two states: RECV (collecting bits) and HOLD (frame presented).
REQ-013 In RECV, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-014 In RECV, each transferred bit SHALL increment a bit counter 0..N; cycles with in_valid=0 SHALL leave all state unchanged.
REQ-015 Data bits (counter 0..N-1) SHALL be stored at shift-register position equal to the counter value and folded into a running XOR.
REQ-016 The bit accepted at counter == N SHALL be the parity bit; on its transfer the FSM SHALL move to HOLD on the same edge and counter SHALL clear to 0.
REQ-017 parity_err SHALL equal NOT(XOR of N data bits XOR parity bit), i.e. 1 when the total count of ones across N+1 bits is even.
REQ-018 out_valid SHALL assert the cycle after the parity bit transfer (latency 1 cycle).
REQ-019 In HOLD, data_out and parity_err SHALL stay stable until out_ready=1; on that edge the FSM SHALL return to RECV with running XOR cleared.
REQ-020 Back-to-back frames: the first bit of the next frame SHALL be acceptable the cycle after the HOLD->RECV transition; no bit SHALL be accepted in HOLD.
REQ-021 data_out SHALL be undefined-free: it SHALL hold its last value outside HOLD, only out_valid qualifies it.

Reset
REQ-022 On rst_n=0 the FSM SHALL enter RECV, counter and running XOR SHALL clear, data_out SHALL be 0, parity_err 0, out_valid 0, err_count 0, asynchronously.
REQ-023 Reset mid-frame or in HOLD SHALL discard the partial/pending frame; the first bit after reset release SHALL be data bit 0.
REQ-024 in_ready SHALL be 1 from the first clock after reset release.

Configuration
REQ-025 Macro PARITY_ERR_COUNT_EN SHALL control the error counter.
REQ-026 With PARITY_ERR_COUNT_EN defined, err_count SHALL increment by 1 on each HOLD entry with parity_err=1, saturating at 255.
REQ-027 Without PARITY_ERR_COUNT_EN, err_count SHALL be constant 0 and no counter register SHALL exist; the port list SHALL be identical.

Verification
REQ-028 N=4, bits 1,1,0,1 (data 4'b1011) then parity 0 -> next cycle out_valid=1, data_out=4'b1011, parity_err=0.
REQ-029 N=4, data 4'b1011, parity 1 -> data_out=4'b1011, parity_err=1; with macro, err_count 0->1.
REQ-030 N=4, data 4'b0000 with in_valid gaps of 3 cycles between bits, parity 1 -> parity_err=0, data_out=4'b0000, no state change during gaps.
REQ-031 Hold out_ready=0 for 5 cycles after frame -> in_ready=0, outputs stable, in_bit toggling ignored; out_ready=1 -> RECV next cycle, next frame received correctly.
REQ-032 Assert rst_n=0 after 2 data bits -> all outputs 0; fresh frame 4'b0110 parity 1 -> data_out=4'b0110, parity_err=0.
REQ-033 With macro, 260 consecutive error frames -> err_count saturates at 255.
